// File: rtl/if_id_pipeline_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipeline_reg
//
// IF/ID pipeline register of the MIPS core. It sits between instruction fetch
// (PC incrementer + instruction cache) and decode. The fetched instruction,
// its next-PC value and the cache hit flag are captured on every rising edge,
// so decode sees stable values for one full cycle.
//
// Priority at each rising edge: rst > flush > stall > normal load.
//   rst / flush : load a bubble (next_pc_out = 0, instruction_out = NOP_INSTR,
//                 hit_out = 0)
//   stall       : hold all three outputs, ignore the inputs
//   otherwise   : capture next_pc / instruction / hit unchanged
//
// A cache miss is captured as-is. The instruction word is not gated, and
// hit_out = 0 marks it invalid. Decode qualifies on hit_out.
//
// Ports:
//   clk              in   pipeline clock, rising-edge active
//   rst              in   synchronous reset, active-high
//   stall            in   1 = hold contents (hazard unit stall)
//   flush            in   1 = insert bubble (branch/jump taken)
//   next_pc          in   [PC_WIDTH-1:0]    PC+4 from fetch
//   instruction      in   [INSTR_WIDTH-1:0] word from instruction cache
//   hit              in   instruction cache hit
//   next_pc_out      out  [PC_WIDTH-1:0]    registered next_pc
//   instruction_out  out  [INSTR_WIDTH-1:0] registered instruction
//   hit_out          out  registered hit flag
// ---------------------------------------------------------------------------
module if_id_pipeline_reg #(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    next_pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   hit,
  output logic [PC_WIDTH-1:0]    next_pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   hit_out
);

  logic [PC_WIDTH-1:0]    next_pc_reg,     next_pc_next;
  logic [INSTR_WIDTH-1:0] instruction_reg, instruction_next;
  logic                   hit_reg,         hit_next;

  // Next-state selection for everything except reset. Reset is handled in the
  // register process so that it wins over every other control.
  always_comb begin
    next_pc_next     = next_pc_reg;
    instruction_next = instruction_reg;
    hit_next         = hit_reg;
    if (flush) begin
      // Bubble. This also takes priority over a simultaneous stall, so a taken
      // branch squashes the wrong-path instruction even while IF is stalled.
      next_pc_next     = '0;
      instruction_next = NOP_INSTR;
      hit_next         = 1'b0;
    end else if (!stall) begin
      next_pc_next     = next_pc;
      instruction_next = instruction;
      hit_next         = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_reg     <= '0;
      instruction_reg <= NOP_INSTR;
      hit_reg         <= 1'b0;
    end else begin
      next_pc_reg     <= next_pc_next;
      instruction_reg <= instruction_next;
      hit_reg         <= hit_next;
    end
  end

  // The outputs come straight from the flops. There is no combinational path
  // from the inputs to the outputs.
  assign next_pc_out     = next_pc_reg;
  assign instruction_out = instruction_reg;
  assign hit_out         = hit_reg;

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
module tb_if_id_pipeline_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] next_pc;
  logic [31:0] instruction;
  logic        hit;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;
  logic        hit_out;

  int vectors     = 0;
  int miscompares = 0;

  if_id_pipeline_reg #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .NOP_INSTR   (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .next_pc         (next_pc),
    .instruction     (instruction),
    .hit             (hit),
    .next_pc_out     (next_pc_out),
    .instruction_out (instruction_out),
    .hit_out         (hit_out)
  );

  // 50 ns period: rising edges at 25, 75, 125, ... ns
  initial clk = 1'b0;
  always #25 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        hit;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_hit;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // Reference model state, built only from the priority rules.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_hit;

  task automatic check(input string name, input logic [31:0] pc_e,
                       input logic [31:0] instr_e, input logic hit_e);
    vectors++;
    if (next_pc_out !== pc_e || instruction_out !== instr_e || hit_out !== hit_e) begin
      miscompares++;
      $display("FAIL %s: got pc=%h instr=%h hit=%b, expected pc=%h instr=%h hit=%b",
               name, next_pc_out, instruction_out, hit_out, pc_e, instr_e, hit_e);
    end else begin
      $display("ok   %s: pc=%h instr=%h hit=%b", name, next_pc_out, instruction_out, hit_out);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [31:0] pc, input logic [31:0] ins, input logic h);
    rst = r; stall = s; flush = f; next_pc = pc; instruction = ins; hit = h;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    //          name             rst stall flush pc           instr         hit  exp_pc        exp_instr     exp_hit
    vecs[0]  = '{"reset_1",       1, 0, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1, 32'h0,         32'h0000_0000, 0};
    vecs[1]  = '{"reset_2",       1, 0, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1, 32'h0,         32'h0000_0000, 0};
    vecs[2]  = '{"load_miss",     0, 0, 0, 32'h0000_000C, 32'hAAAA_AAAA, 0, 32'h0000_000C, 32'hAAAA_AAAA, 0};
    vecs[3]  = '{"load_hit",      0, 0, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1, 32'h0000_000C, 32'hAAAA_AAAA, 1};
    vecs[4]  = '{"stall_1",       0, 1, 0, 32'h0000_0010, 32'h5555_5555, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1};
    vecs[5]  = '{"stall_2",       0, 1, 0, 32'h0000_0010, 32'h5555_5555, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1};
    vecs[6]  = '{"stall_3",       0, 1, 0, 32'h0000_0010, 32'h5555_5555, 0, 32'h0000_000C, 32'hAAAA_AAAA, 1};
    vecs[7]  = '{"stall_release", 0, 0, 0, 32'h0000_0010, 32'h5555_5555, 0, 32'h0000_0010, 32'h5555_5555, 0};
    vecs[8]  = '{"flush_stall",   0, 1, 1, 32'h0000_0020, 32'h1234_5678, 1, 32'h0,         32'h0000_0000, 0};
    vecs[9]  = '{"after_flush",   0, 0, 0, 32'h0000_0024, 32'h8C22_0004, 1, 32'h0000_0024, 32'h8C22_0004, 1};
    vecs[10] = '{"rst_over_stall",1, 1, 0, 32'h0000_0028, 32'hFFFF_FFFF, 1, 32'h0,         32'h0000_0000, 0};
    vecs[11] = '{"after_rst",     0, 0, 0, 32'h0000_002C, 32'hDEAD_BEEF, 0, 32'h0000_002C, 32'hDEAD_BEEF, 0};
    vecs[12] = '{"flush_only",    0, 0, 1, 32'h0000_0030, 32'hCAFE_F00D, 1, 32'h0,         32'h0000_0000, 0};
    vecs[13] = '{"rst_and_flush", 1, 1, 1, 32'h0000_0034, 32'h0BAD_CAFE, 1, 32'h0,         32'h0000_0000, 0};

    // Table-driven vectors: drive on the falling edge, sample 1 ns after the rising edge.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].pc, vecs[i].instr, vecs[i].hit);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_hit);
    end

    // Hand sequence: the outputs do not change before the edge (no combinational path).
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);
    @(posedge clk); #1;
    check("seq_load", 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0F0F_0F0F, 1'b1);
    #5;
    check("seq_no_comb_path", 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);
    // Glitch the inputs mid-cycle and restore them. Only the value at the edge matters.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    #5;
    drive(1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);
    @(posedge clk); #1;
    check("seq_glitch_ignored", 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);

    // Hand sequence: hit rises mid-cycle, and hit_out follows at the next edge only.
    @(negedge clk); #10;
    hit = 1'b1;
    #5;
    check("seq_hit_before_edge", 32'h0000_000C, 32'hAAAA_AAAA, 1'b0);
    @(posedge clk); #1;
    check("seq_hit_after_edge", 32'h0000_000C, 32'hAAAA_AAAA, 1'b1);

    // Randomized stimulus checked against the reference model.
    m_pc = next_pc_out === 32'h0000_000C ? 32'h0000_000C : 32'hx;
    m_pc = 32'h0000_000C; m_instr = 32'hAAAA_AAAA; m_hit = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(($urandom_range(15) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
            $urandom, $urandom, $urandom_range(1) == 1);
      if (rst || flush) begin
        m_pc = 32'h0; m_instr = 32'h0000_0000; m_hit = 1'b0;
      end else if (!stall) begin
        m_pc = next_pc; m_instr = instruction; m_hit = hit;
      end
      @(posedge clk); #1;
      check($sformatf("rand_%0d r%0b f%0b s%0b", n, rst, flush, stall), m_pc, m_instr, m_hit);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_pipeline_reg.md
Name: if_id_pipeline_reg

Overview:
IF/ID pipeline register of the MIPS core, between instruction fetch (PC incrementer + instruction cache) and decode. Captures the fetched instruction, its next-PC value and the cache hit flag on every rising clock edge, so decode sees stable values for one full cycle. Supports stall (hold contents) and flush (insert bubble) for hazard and branch handling.

Parameters:
PC_WIDTH, 32, width of next_pc path.
INSTR_WIDTH, 32, width of instruction path.
NOP_INSTR, 32'h0000_0000, instruction word loaded on reset/flush (MIPS sll $0,$0,0).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
stall  input  1  1 = hold all outputs (IF stalled by hazard unit).
flush  input  1  1 = load bubble (branch/jump taken).
next_pc  input  PC_WIDTH  PC+4 from fetch stage.
instruction  input  INSTR_WIDTH  instruction word from instruction cache.
hit  input  1  instruction cache hit; instruction is valid when 1.
next_pc_out  output  PC_WIDTH  registered next_pc to ID.
instruction_out  output  INSTR_WIDTH  registered instruction to ID.
hit_out  output  1  registered hit flag to ID.

Behaviour:
- Single clock domain, rising-edge registers only; reset synchronous and active-high; no combinational input-to-output path.
- Outputs are plain flop outputs; latency exactly 1 clock edge from input to output.
- Priority at each rising edge: rst > flush > stall > normal load.
- rst=1: next_pc_out <= 0, instruction_out <= NOP_INSTR, hit_out <= 0. These are the reset values of every output.
- flush=1 (rst=0): instruction_out <= NOP_INSTR, hit_out <= 0, next_pc_out <= 0. Flush overrides a simultaneous stall.
- stall=1 (rst=0, flush=0): all three outputs keep their current values; inputs ignored.
- Normal (rst=0, flush=0, stall=0): next_pc_out <= next_pc, instruction_out <= instruction, hit_out <= hit.
- A miss (hit=0) is still captured unmodified: instruction word passed as-is, hit_out=0 marks it invalid. Decode must qualify on hit_out; this block does not gate the instruction on a miss.
- No internal state beyond the three output registers; no wrap-around or counters.
- Before the first reset, output values are undefined (X in simulation). Benches must assert rst at least one edge before checking.
- Reset asserted mid-operation takes effect at the next rising edge regardless of stall/flush; deassertion resumes normal loading at the following edge.
- Inputs changing between edges have no effect until the next rising edge.

Test Plan:
1. Reset: rst=1 for 2 edges with next_pc=0xC, instruction=0xAAAAAAAA, hit=1 -> next_pc_out=0, instruction_out=0x00000000, hit_out=0.
2. Load with miss: rst=0, next_pc=0x0000000C, instruction=0xAAAAAAAA, hit=0 -> after next edge next_pc_out=0xC, instruction_out=0xAAAAAAAA, hit_out=0. Values unchanged before that edge.
3. Hit transition: at t=100ns set hit=1 with the same pc/instruction (clock period 50ns) -> hit_out=1 from the first rising edge after 100ns. pc/instruction outputs are stable throughout.
4. Stall: outputs holding 0xC/0xAAAAAAAA/1, apply stall=1 with next_pc=0x10, instruction=0x55555555 for 3 edges -> outputs stay 0xC/0xAAAAAAAA/1. Release -> 0x10/0x55555555 after one edge.
5. Flush priority: stall=1 and flush=1 on the same edge -> next_pc_out=0, instruction_out=0, hit_out=0. Drop both -> normal load resumes next edge.
6. Reset priority: rst=1 with flush=0, stall=1 while outputs hold nonzero data -> reset values at the next edge.
